// File: rtl/alu_arbiter_if.sv
// Handshake bundle around the shared ALU: two request ports, the ALU operand/result
// path and the tagged response port. The arbiter sits on the slave side.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data1;
  logic [DATA_W-1:0] req0_data2;
  logic [SEL_W-1:0]  req0_select;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data1;
  logic [DATA_W-1:0] req1_data2;
  logic [SEL_W-1:0]  req1_select;
  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic [SEL_W-1:0]  alu_select;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;

  modport slave (
    input  req0_valid, req0_data1, req0_data2, req0_select,
    input  req1_valid, req1_data1, req1_data2, req1_select,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_data1, alu_data2, alu_select,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport master (
    output req0_valid, req0_data1, req0_data2, req0_select,
    output req1_valid, req1_data1, req1_data2, req1_select,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_data1, alu_data2, alu_select,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; one operation
// is in flight at a time and its result is returned tagged with the requester ID.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t            state_r;
  logic              rr_ptr_r;
  logic              rsp_valid_r;
  logic              rsp_id_r;
  logic              rsp_zero_r;
  logic [DATA_W-1:0] rsp_result_r;
  logic [DATA_W-1:0] alu_data1_r;
  logic [DATA_W-1:0] alu_data2_r;
  logic [SEL_W-1:0]  alu_select_r;
  logic              grant_s;
  logic              ready0_s;
  logic              ready1_s;
  logic              accept_s;

  // Grant selection: the sole valid requester, or the rr pointer's choice on contention.
  always_comb begin
    grant_s  = 1'b0;
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = rr_ptr_r;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    // Ready is gated by rst_n so it drops the instant reset asserts.
    if (rst_n && (state_r == ST_IDLE)) begin
      ready0_s = bus.req0_valid & ~grant_s;
      ready1_s = bus.req1_valid & grant_s;
    end else begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end
  end

  assign accept_s = ready0_s | ready1_s;

  // Operation sequencer: latch operands, capture the ALU result, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_zero_r   <= 1'b0;
      rsp_result_r <= {DATA_W{1'b0}};
      alu_data1_r  <= {DATA_W{1'b0}};
      alu_data2_r  <= {DATA_W{1'b0}};
      alu_select_r <= {SEL_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            alu_data1_r  <= grant_s ? bus.req1_data1  : bus.req0_data1;
            alu_data2_r  <= grant_s ? bus.req1_data2  : bus.req0_data2;
            alu_select_r <= grant_s ? bus.req1_select : bus.req0_select;
            rsp_id_r     <= grant_s;
            state_r      <= ST_EXEC;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_result_r <= bus.alu_result;
          rsp_zero_r   <= bus.alu_zero;
          rsp_valid_r  <= 1'b1;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          // The pointer moves only when a response is consumed, so contention alternates.
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rr_ptr_r    <= ~rsp_id_r;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.alu_data1  = alu_data1_r;
  assign bus.alu_data2  = alu_data2_r;
  assign bus.alu_select = alu_select_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_zero   = rsp_zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic from both requesters,
// with a transaction scoreboard and an arbitration model checked every cycle.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   rsp_mode = 1;

  alu_arbiter_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  alu_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: 000 pass DATA2, 001 add, 010 and, 011 or, 100 sub, others 0.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] s);
    case (s)
      3'b000:  return b;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a - b;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] alu_tmp;
  always_comb begin
    alu_tmp        = alu_fn(bus.alu_data1, bus.alu_data2, bus.alu_select);
    bus.alu_result = alu_tmp;
    bus.alu_zero   = (alu_tmp == 32'd0);
  end

  typedef struct {
    bit          id;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  sel;
    logic [31:0] res;
    bit          zero;
    int          due;
  } txn_t;

  txn_t sbq[$];
  txn_t t;
  bit   ptr_m = 1'b0;
  bit   rsp_seen = 1'b0;
  bit   m_v0, m_v1, m_busy, m_g;
  logic [1:0] m_exp_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic push(input bit id, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] s);
    t.id   = id;
    t.d1   = a;
    t.d2   = b;
    t.sel  = s;
    t.res  = alu_fn(a, b, s);
    t.zero = (t.res == 32'd0);
    t.due  = cyc + 2;
    sbq.push_back(t);
  endtask

  // Monitor: arbitration model, operand hold, response scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      ptr_m    = 1'b0;
      rsp_seen = 1'b0;
    end else begin
      m_v0      = bus.req0_valid;
      m_v1      = bus.req1_valid;
      m_busy    = (sbq.size() != 0);
      m_g       = (m_v0 && m_v1) ? ptr_m : m_v1;
      m_exp_rdy = m_busy ? 2'b00 : {m_v1 & m_g, m_v0 & ~m_g};
      if (m_v0 || m_v1 || bus.req0_ready || bus.req1_ready)
        check("req_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(m_exp_rdy));
      if (m_busy) begin
        check("alu_data1", 64'(bus.alu_data1), 64'(sbq[0].d1));
        check("alu_data2", 64'(bus.alu_data2), 64'(sbq[0].d2));
        check("alu_select", 64'(bus.alu_select), 64'(sbq[0].sel));
        if (bus.rsp_valid) begin
          if (!rsp_seen) check("rsp_latency", 64'(cyc), 64'(sbq[0].due));
          check("rsp_id", 64'(bus.rsp_id), 64'(sbq[0].id));
          check("rsp_result", 64'(bus.rsp_result), 64'(sbq[0].res));
          check("rsp_zero", 64'(bus.rsp_zero), 64'(sbq[0].zero));
          rsp_seen = 1'b1;
          if (bus.rsp_ready) begin
            ptr_m = ~sbq[0].id;
            void'(sbq.pop_front());
            rsp_seen = 1'b0;
          end
        end else if (cyc >= sbq[0].due) begin
          fail("rsp_missing");
        end
      end else if (bus.rsp_valid) begin
        fail("rsp_unexpected");
      end
      if (m_v0 && bus.req0_ready)
        push(1'b0, bus.req0_data1, bus.req0_data2, bus.req0_select);
      else if (m_v1 && bus.req1_ready)
        push(1'b1, bus.req1_data1, bus.req1_data2, bus.req1_select);
    end
  end

  // Response consumer: always ready, stalled, or random per cycle.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       bus.rsp_ready = 1'b0;
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] s);
    int  n = 0;
    bit  hs = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_data1 = a; bus.req1_data2 = b; bus.req1_select = s;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_data1 = a; bus.req0_data2 = b; bus.req0_select = s;
    end
    while (!hs && n < 200) begin
      @(negedge clk);
      n++;
      hs = id ? (bus.req1_valid & bus.req1_ready) : (bus.req0_valid & bus.req0_ready);
    end
    if (!hs) fail(id ? "req1_timeout" : "req0_timeout");
    @(posedge clk);
    #1;
    // Scramble operands after the handshake; they must already be latched.
    if (id) begin
      bus.req1_valid = 1'b0; bus.req1_data1 = $urandom; bus.req1_data2 = $urandom;
      bus.req1_select = 3'($urandom_range(0, 7));
    end else begin
      bus.req0_valid = 1'b0; bus.req0_data1 = $urandom; bus.req0_data2 = $urandom;
      bus.req0_select = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
    check({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'd0);
    check({tag, "_rsp_zero"}, 64'(bus.rsp_zero), 64'd0);
    check({tag, "_alu_data1"}, 64'(bus.alu_data1), 64'd0);
    check({tag, "_alu_data2"}, 64'(bus.alu_data2), 64'd0);
    check({tag, "_alu_select"}, 64'(bus.alu_select), 64'd0);
    check({tag, "_ready"}, 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
  endtask

  task automatic rand_requester(input bit id, input int ops);
    for (int i = 0; i < ops; i++) begin
      int gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      issue(id, $urandom, (i % 5 == 0) ? 32'd0 : $urandom, 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_data1 = 32'd0; bus.req0_data2 = 32'd0; bus.req0_select = 3'd0;
    bus.req1_valid = 1'b0; bus.req1_data1 = 32'd0; bus.req1_data2 = 32'd0; bus.req1_select = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check_reset_vals("por");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention straight after reset: req0 first, then req1.
    fork
      issue(1'b0, 32'hFF00, 32'h0FF0, 3'b010);
      issue(1'b1, 32'h1, 32'h2, 3'b011);
    join
    drain();

    // Single add.
    issue(1'b0, 32'd5, 32'd7, 3'b001);
    drain();

    // Both continuously valid for four operations: strict alternation.
    fork
      begin issue(1'b0, 32'd10, 32'd3, 3'b100); issue(1'b0, 32'd20, 32'd20, 3'b100); end
      begin issue(1'b1, 32'd1, 32'hFFFF_FFFF, 3'b001); issue(1'b1, 32'hA5, 32'h5A, 3'b011); end
    join
    drain();

    // Consumer stalls: response and ALU operands must hold, no new grant.
    rsp_mode = 0;
    fork
      issue(1'b0, 32'h1234, 32'h1111, 3'b001);
      issue(1'b1, 32'h8, 32'h8, 3'b100);
      begin repeat (8) @(posedge clk); #1; rsp_mode = 1; end
    join
    drain();

    // Zero flag and unused select code.
    issue(1'b1, 32'hF0, 32'h0F, 3'b010);
    drain();
    issue(1'b0, 32'h77, 32'd9, 3'b111);
    drain();

    // Reset while an operation is executing.
    issue(1'b1, 32'hDEAD, 32'hBEEF, 3'b001);
    rst_n = 1'b0;
    #1;
    check_reset_vals("exec_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    fork
      issue(1'b0, 32'd3, 32'd4, 3'b001);
      issue(1'b1, 32'd6, 32'd6, 3'b100);
    join
    drain();

    // Random traffic with a randomly stalling consumer.
    rsp_mode = 2;
    fork
      rand_requester(1'b0, 40);
      rand_requester(1'b1, 40);
    join
    rsp_mode = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
